// File: rtl/draw_sprite.sv
// ---------------------------------------------------------------------------
// draw_sprite
//
// Bitmap sprite plotter for the VGA adapter pixel port. A start pulse in IDLE
// latches the anchor (x, y) and the draw colour. The block then raster-scans a
// W x H bitmap row-major, col fastest, and emits one pixel per cycle on
// xout/yout/colour. plot is high only for pixels whose bitmap bit is set. A
// one-cycle done pulse follows the last pixel.
//
// Optional feature macro: DRAW_SPRITE_ERASE_EN
//   When defined, the erase port and the BG_COLOUR parameter exist. A latched
//   erase=1 makes every set pixel use BG_COLOUR instead of colour_in. The mask
//   and the timing do not change.
//   When undefined, colour is always the latched colour_in.
//
// Ports
//   clk        in   1    clock
//   reset_n    in   1    asynchronous active-low reset
//   start      in   1    begin a draw (sampled only in IDLE)
//   x          in   XW   anchor x, latched on accepted start
//   y          in   YW   anchor y, latched on accepted start
//   colour_in  in   CW   draw colour, latched on accepted start
//   erase      in   1    erase request, latched on accepted start
//                        (DRAW_SPRITE_ERASE_EN only)
//   busy       out  1    high from accept through the last pixel cycle
//   plot       out  1    write enable for the current xout/yout/colour
//   xout       out  XW   x + col, modulo 2^XW
//   yout       out  YW   y + row, modulo 2^YW
//   colour     out  CW   pixel colour
//   done       out  1    one-cycle pulse after the last pixel
// ---------------------------------------------------------------------------
module draw_sprite #(
    parameter int W  = 16,
    parameter int H  = 16,
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 3,
    parameter logic [W*H-1:0] BITMAP = {W*H{1'b1}}
`ifdef DRAW_SPRITE_ERASE_EN
    ,
    parameter logic [CW-1:0] BG_COLOUR = {CW{1'b0}}
`endif
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [CW-1:0] colour_in,
`ifdef DRAW_SPRITE_ERASE_EN
    input  logic          erase,
`endif
    output logic          busy,
    output logic          plot,
    output logic [XW-1:0] xout,
    output logic [YW-1:0] yout,
    output logic [CW-1:0] colour,
    output logic          done
);

    localparam int CNTW = $clog2(W + 1);
    localparam int RW   = $clog2(H + 1);
    localparam int KW   = $clog2(W * H + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [CNTW-1:0] col;
    logic [RW-1:0]   row;
    logic [KW-1:0]   pix;
    logic            scan_end;

    logic [XW-1:0]   x_lat;
    logic [YW-1:0]   y_lat;
    logic [CW-1:0]   colour_lat;
    logic [CW-1:0]   draw_colour;

    logic            accept;
    logic            last_pixel;

    assign accept     = (state == IDLE) && start;
    assign last_pixel = (pix == KW'(W * H - 1));

`ifdef DRAW_SPRITE_ERASE_EN
    logic erase_lat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            erase_lat <= 1'b0;
        end else if (accept) begin
            erase_lat <= erase;
        end
    end

    assign draw_colour = erase_lat ? BG_COLOUR : colour_lat;
`else
    assign draw_colour = colour_lat;
`endif

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. SCAN lasts one cycle longer than the pixel count.
    // The first SCAN cycle only holds the latched request, and the pixels
    // then appear one edge later each. scan_end marks that the last pixel
    // is already on the outputs, so the following edge moves to DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)    next_state = SCAN;
            SCAN:    if (scan_end) next_state = DONE;
            DONE:                  next_state = IDLE;
            default:               next_state = IDLE;
        endcase
    end

    // Status outputs decode directly from the registered state.
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SCAN:    busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    // Request latch, scan counters and registered pixel outputs.
    // pix tracks the linear bitmap index, so the mask bit needs no
    // multiply. col/row drive the coordinate adders.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_lat      <= '0;
            y_lat      <= '0;
            colour_lat <= '0;
            col        <= '0;
            row        <= '0;
            pix        <= '0;
            scan_end   <= 1'b0;
            plot       <= 1'b0;
            xout       <= '0;
            yout       <= '0;
            colour     <= '0;
        end else if (accept) begin
            x_lat      <= x;
            y_lat      <= y;
            colour_lat <= colour_in;
            col        <= '0;
            row        <= '0;
            pix        <= '0;
            scan_end   <= 1'b0;
            plot       <= 1'b0;
        end else if (state == SCAN && !scan_end) begin
            xout   <= x_lat + XW'(col);
            yout   <= y_lat + YW'(row);
            colour <= draw_colour;
            plot   <= BITMAP[pix];
            if (last_pixel) begin
                scan_end <= 1'b1;
                col      <= '0;
                row      <= '0;
                pix      <= '0;
            end else begin
                pix <= pix + 1'b1;
                if (col == CNTW'(W - 1)) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end else begin
            plot <= 1'b0;
        end
    end

endmodule

// File: tb/tb_draw_sprite.sv
// ---------------------------------------------------------------------------
// tb_draw_sprite
//
// Self-checking bench for draw_sprite. It uses two instances:
//   dut  : W=4, H=2, BITMAP=8'b1010_0110 (main function, wrap, mid-draw reset)
//   dut1 : W=1, H=1, BITMAP=1'b1         (single-pixel draw, back-to-back start)
// The expected per-cycle behaviour comes from plain arithmetic on the pixel
// index: col = k % W, row = k / W, coordinates modulo the port width.
// ---------------------------------------------------------------------------
module tb_draw_sprite;

    localparam int SW = 4;
    localparam int SH = 2;
    localparam logic [7:0] SPRITE = 8'b1010_0110;

    logic       clk;
    logic       reset_n;

    logic       start;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colourIn;
    logic       busy, plot, done;
    logic [7:0] xout;
    logic [6:0] yout;
    logic [2:0] colour;

    logic       start1;
    logic [7:0] x1;
    logic [6:0] y1;
    logic [2:0] colourIn1;
    logic       busy1, plot1, done1;
    logic [7:0] xout1;
    logic [6:0] yout1;
    logic [2:0] colour1;

`ifdef DRAW_SPRITE_ERASE_EN
    logic       erase;
    logic       erase1;
`endif

    int total = 0;
    int bad   = 0;

    // Reference values the outputs must hold when nothing new is emitted.
    logic [7:0] mX;
    logic [6:0] mY;
    logic [2:0] mC;

    draw_sprite #(.W(SW), .H(SH), .XW(8), .YW(7), .CW(3), .BITMAP(SPRITE)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .x         (x),
        .y         (y),
        .colour_in (colourIn),
`ifdef DRAW_SPRITE_ERASE_EN
        .erase     (erase),
`endif
        .busy      (busy),
        .plot      (plot),
        .xout      (xout),
        .yout      (yout),
        .colour    (colour),
        .done      (done)
    );

    draw_sprite #(.W(1), .H(1), .XW(8), .YW(7), .CW(3), .BITMAP(1'b1)) dut1 (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start1),
        .x         (x1),
        .y         (y1),
        .colour_in (colourIn1),
`ifdef DRAW_SPRITE_ERASE_EN
        .erase     (erase1),
`endif
        .busy      (busy1),
        .plot      (plot1),
        .xout      (xout1),
        .yout      (yout1),
        .colour    (colour1),
        .done      (done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] vx;
        logic [6:0] vy;
        logic [2:0] vc;
        bit         repulse;
        logic [7:0] expLastX;
        logic [6:0] expLastY;
        int         expPlots;
    } vec_t;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic eBusy, input logic ePlot, input logic eDone);
        checkOutput({tag, ".busy"},   32'(busy),   32'(eBusy));
        checkOutput({tag, ".plot"},   32'(plot),   32'(ePlot));
        checkOutput({tag, ".done"},   32'(done),   32'(eDone));
        checkOutput({tag, ".xout"},   32'(xout),   32'(mX));
        checkOutput({tag, ".yout"},   32'(yout),   32'(mY));
        checkOutput({tag, ".colour"}, 32'(colour), 32'(mC));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete draw on the 4x2 instance with every cycle checked.
    task automatic applyStimulus(input logic [7:0] xa, input logic [6:0] ya, input logic [2:0] ca,
                                 input bit repulse, input bit er,
                                 output int plots, output logic [7:0] lastX, output logic [6:0] lastY);
        logic [2:0] expC;
        logic       expPlot;
        expC  = er ? 3'b000 : ca;
        plots = 0;
        start    = 1'b1;
        x        = xa;
        y        = ya;
        colourIn = ca;
`ifdef DRAW_SPRITE_ERASE_EN
        erase    = er;
`endif
        tick();
        start    = 1'b0;
        x        = ~xa;
        y        = ~ya;
        colourIn = ~ca;
`ifdef DRAW_SPRITE_ERASE_EN
        erase    = ~er;
`endif
        checkAll("accept", 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < SW * SH; k++) begin
            if (repulse && k == 2) begin
                start    = 1'b1;
                colourIn = ~ca;
                x        = xa + 8'd40;
            end
            tick();
            mX = 8'((int'(xa) + (k % SW)) % 256);
            mY = 7'((int'(ya) + (k / SW)) % 128);
            mC = expC;
            expPlot = SPRITE[k];
            checkAll($sformatf("pix%0d", k), 1'b1, expPlot, 1'b0);
            plots += int'(expPlot);
        end
        lastX = xout;
        lastY = yout;
        start = 1'b0;
        tick();
        checkAll("donecyc", 1'b0, 1'b0, 1'b1);
        tick();
        checkAll("idle", 1'b0, 1'b0, 1'b0);
    endtask

    vec_t vecs[5];
    int   plots;
    logic [7:0] lastX;
    logic [6:0] lastY;

    initial begin
        vecs[0] = '{vx: 8'd10,  vy: 7'd20,  vc: 3'b110, repulse: 1'b0, expLastX: 8'd13,  expLastY: 7'd21,  expPlots: 4};
        vecs[1] = '{vx: 8'd10,  vy: 7'd20,  vc: 3'b110, repulse: 1'b1, expLastX: 8'd13,  expLastY: 7'd21,  expPlots: 4};
        vecs[2] = '{vx: 8'd254, vy: 7'd127, vc: 3'b101, repulse: 1'b0, expLastX: 8'd1,   expLastY: 7'd0,   expPlots: 4};
        vecs[3] = '{vx: 8'd158, vy: 7'd119, vc: 3'b011, repulse: 1'b0, expLastX: 8'd161, expLastY: 7'd120, expPlots: 4};
        vecs[4] = '{vx: 8'd0,   vy: 7'd0,   vc: 3'b111, repulse: 1'b1, expLastX: 8'd3,   expLastY: 7'd1,   expPlots: 4};

        reset_n   = 1'b0;
        start     = 1'b0;
        x         = '0;
        y         = '0;
        colourIn  = '0;
        start1    = 1'b0;
        x1        = '0;
        y1        = '0;
        colourIn1 = '0;
`ifdef DRAW_SPRITE_ERASE_EN
        erase     = 1'b0;
        erase1    = 1'b0;
`endif
        mX = '0;
        mY = '0;
        mC = '0;

        tick();
        tick();
        checkAll("reset", 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        checkAll("postreset", 1'b0, 1'b0, 1'b0);

        // Table-driven draws.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].vx, vecs[i].vy, vecs[i].vc, vecs[i].repulse, 1'b0, plots, lastX, lastY);
            checkOutput($sformatf("vec%0d.lastx", i), 32'(lastX), 32'(vecs[i].expLastX));
            checkOutput($sformatf("vec%0d.lasty", i), 32'(lastY), 32'(vecs[i].expLastY));
            checkOutput($sformatf("vec%0d.plots", i), 32'(plots), 32'(vecs[i].expPlots));
        end

        // Randomized draws with random idle gaps in between.
        for (int r = 0; r < 20; r++) begin
            int gap;
            applyStimulus(8'($urandom), 7'($urandom), 3'($urandom), bit'($urandom_range(0, 1)), 1'b0,
                          plots, lastX, lastY);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                x = 8'($urandom);
                tick();
                checkAll("gap", 1'b0, 1'b0, 1'b0);
            end
        end

        // Asynchronous reset while pixel 3 is on the outputs.
        start    = 1'b1;
        x        = 8'd30;
        y        = 7'd40;
        colourIn = 3'b010;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        mX = 8'd33;
        mY = 7'd40;
        mC = 3'b010;
        checkAll("pre_rst_pix3", 1'b1, SPRITE[3], 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        mX = '0;
        mY = '0;
        mC = '0;
        checkAll("midreset", 1'b0, 1'b0, 1'b0);
        tick();
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checkAll("abandoned", 1'b0, 1'b0, 1'b0);
        end
        applyStimulus(8'd10, 7'd20, 3'b110, 1'b0, 1'b0, plots, lastX, lastY);
        checkOutput("restart.plots", 32'(plots), 32'd4);

`ifdef DRAW_SPRITE_ERASE_EN
        applyStimulus(8'd10, 7'd20, 3'b110, 1'b0, 1'b1, plots, lastX, lastY);
        checkOutput("erase.plots", 32'(plots), 32'd4);
`endif

        // Single-pixel sprite with a start held through and after done.
        start1    = 1'b1;
        x1        = 8'd50;
        y1        = 7'd60;
        colourIn1 = 3'b011;
        tick();
        start1 = 1'b0;
        x1     = 8'd0;
        checkOutput("one.accept.busy", 32'(busy1), 32'd1);
        checkOutput("one.accept.plot", 32'(plot1), 32'd0);
        tick();
        checkOutput("one.pix.plot",   32'(plot1),   32'd1);
        checkOutput("one.pix.busy",   32'(busy1),   32'd1);
        checkOutput("one.pix.xout",   32'(xout1),   32'd50);
        checkOutput("one.pix.yout",   32'(yout1),   32'd60);
        checkOutput("one.pix.colour", 32'(colour1), 32'd3);
        start1    = 1'b1;
        x1        = 8'd70;
        y1        = 7'd5;
        colourIn1 = 3'b100;
        tick();
        checkOutput("one.done.done", 32'(done1), 32'd1);
        checkOutput("one.done.busy", 32'(busy1), 32'd0);
        checkOutput("one.done.plot", 32'(plot1), 32'd0);
        tick();
        checkOutput("one.ignored.busy", 32'(busy1), 32'd0);
        checkOutput("one.ignored.done", 32'(done1), 32'd0);
        tick();
        checkOutput("one.again.busy", 32'(busy1), 32'd1);
        start1 = 1'b0;
        tick();
        checkOutput("one.again.plot", 32'(plot1), 32'd1);
        checkOutput("one.again.xout", 32'(xout1), 32'd70);
        checkOutput("one.again.yout", 32'(yout1), 32'd5);
        checkOutput("one.again.colour", 32'(colour1), 32'd4);
        tick();
        checkOutput("one.again.done", 32'(done1), 32'd1);
        tick();
        checkOutput("one.final.done", 32'(done1), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
